// File: rtl/papuf_eval_ctrl.sv
//==============================================================================
// Module   : papuf_eval_ctrl
// Function : papuf16 evaluation sequencer returning a per-bit majority vote over
//            NUM_EVAL evaluations. PAPUF_STABILITY_FLAG_EN adds resp_unstable.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module papuf_eval_ctrl #(
   parameter int NUM_EVAL   = 5,
   parameter int SETUP_CYC  = 2,
   parameter int PULSE_CYC  = 4,
   parameter int SETTLE_CYC = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_challenge,
   output logic [15:0] puf_challenge,
   output logic        puf_pulse,
   input  logic [15:0] puf_response,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_data,
`ifdef PAPUF_STABILITY_FLAG_EN
   output logic [15:0] resp_unstable,
`endif
   output logic        busy
);

   localparam int c_vote_w  = $clog2(NUM_EVAL + 1);
   localparam int c_max_cyc = (SETUP_CYC > PULSE_CYC)
                              ? ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC)
                              : ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
   localparam int c_cyc_w   = $clog2(c_max_cyc + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_PULSE  = 3'd2,
      S_SETTLE = 3'd3,
      S_SAMPLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              r_state;
   logic [15:0]         r_sync1;
   logic [15:0]         r_sync2;
   logic [c_vote_w-1:0] r_vote [16];
   logic [c_vote_w-1:0] r_eval_cnt;
   logic [c_cyc_w-1:0]  r_phase_cnt;
   logic [15:0]         w_majority;
   logic                w_accept;

   assign w_accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= puf_response;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) r_vote[i] <= '0;
      end else if (r_state == S_IDLE && w_accept) begin
         for (int i = 0; i < 16; i++) r_vote[i] <= '0;
      end else if (r_state == S_SAMPLE) begin
         for (int i = 0; i < 16; i++) r_vote[i] <= r_vote[i] + c_vote_w'(r_sync2[i]);
      end
   end

`ifdef PAPUF_STABILITY_FLAG_EN
   logic [15:0] w_unstable;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_vote
         assign w_majority[gi] = (r_vote[gi] > c_vote_w'(NUM_EVAL / 2));
`ifdef PAPUF_STABILITY_FLAG_EN
         assign w_unstable[gi] = (r_vote[gi] != '0) && (r_vote[gi] != c_vote_w'(NUM_EVAL));
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_eval_cnt    <= '0;
         r_phase_cnt   <= '0;
         puf_challenge <= '0;
         puf_pulse     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         busy          <= 1'b0;
         cmd_ready     <= 1'b1;
`ifdef PAPUF_STABILITY_FLAG_EN
         resp_unstable <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  puf_challenge <= cmd_challenge;
                  r_eval_cnt    <= '0;
                  r_phase_cnt   <= '0;
                  busy          <= 1'b1;
                  cmd_ready     <= 1'b0;
                  r_state       <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_phase_cnt == c_cyc_w'(SETUP_CYC - 1)) begin
                  r_phase_cnt <= '0;
                  puf_pulse   <= 1'b1;
                  r_state     <= S_PULSE;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            S_PULSE: begin
               if (r_phase_cnt == c_cyc_w'(PULSE_CYC - 1)) begin
                  r_phase_cnt <= '0;
                  puf_pulse   <= 1'b0;
                  r_state     <= S_SETTLE;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_phase_cnt == c_cyc_w'(SETTLE_CYC - 1)) begin
                  r_phase_cnt <= '0;
                  r_state     <= S_SAMPLE;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            S_SAMPLE: begin
               r_eval_cnt <= r_eval_cnt + 1'b1;
               if (r_eval_cnt == c_vote_w'(NUM_EVAL - 1)) r_state <= S_DONE;
               else                                       r_state <= S_SETUP;
            end
            S_DONE: begin
               // Final votes land on DONE entry, so the result is registered one cycle later.
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_data  <= w_majority;
`ifdef PAPUF_STABILITY_FLAG_EN
                  resp_unstable <= w_unstable;
`endif
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  cmd_ready  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_papuf_eval_ctrl.sv
//==============================================================================
// Module   : tb_papuf_eval_ctrl
// Function : Self-checking bench for papuf_eval_ctrl against a timeline model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_papuf_eval_ctrl;

   localparam int c_n      = 5;
   localparam int c_setup  = 2;
   localparam int c_pulse  = 4;
   localparam int c_settle = 4;
   localparam int c_p      = c_setup + c_pulse + c_settle + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_challenge = '0;
   logic [15:0] puf_challenge;
   logic        puf_pulse;
   logic [15:0] puf_response = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [15:0] resp_data;
   logic        busy;

   logic        cmd_valid1 = 1'b0;
   logic        cmd_ready1;
   logic [15:0] cmd_challenge1 = '0;
   logic [15:0] puf_challenge1;
   logic        puf_pulse1;
   logic [15:0] puf_response1;
   logic        resp_valid1;
   logic [15:0] resp_data1;
   logic        busy1;
`ifdef PAPUF_STABILITY_FLAG_EN
   logic [15:0] resp_unstable;
   logic [15:0] resp_unstable1;
`endif

   assign puf_response1 = puf_challenge1 ^ 16'hA5A5;

   always #5 clk = ~clk;

   papuf_eval_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_challenge(cmd_challenge), .puf_challenge(puf_challenge), .puf_pulse(puf_pulse),
      .puf_response(puf_response), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data),
`ifdef PAPUF_STABILITY_FLAG_EN
      .resp_unstable(resp_unstable),
`endif
      .busy(busy)
   );

   papuf_eval_ctrl #(.NUM_EVAL(1), .SETUP_CYC(1), .PULSE_CYC(1), .SETTLE_CYC(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_challenge(cmd_challenge1), .puf_challenge(puf_challenge1), .puf_pulse(puf_pulse1),
      .puf_response(puf_response1), .resp_valid(resp_valid1), .resp_ready(1'b1),
      .resp_data(resp_data1),
`ifdef PAPUF_STABILITY_FLAG_EN
      .resp_unstable(resp_unstable1),
`endif
      .busy(busy1)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transaction is a timeline of cycles counted from the accept edge.
   logic [15:0] drv_mask [16];
   bit          m_busy, m_valid, exp_pulse, prev_pulse, prev_valid;
   int          m_c, drv_e, st_rises, st_cycles, rec_lat;
   logic [15:0] m_chal, m_data, m_unst, rec_data, rec_unst;

   always begin
      @(posedge clk);
      if (!rst_n) begin
         m_busy = 0; m_valid = 0; m_c = 0; m_chal = '0; drv_e = 0;
         prev_pulse = 0; prev_valid = 0;
         #1;
         chk("rst_cmd_ready", cmd_ready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_pulse", puf_pulse, 0);
         chk("rst_valid", resp_valid, 0);
         chk("rst_data", resp_data, 0);
         chk("rst_challenge", puf_challenge, 0);
`ifdef PAPUF_STABILITY_FLAG_EN
         chk("rst_unstable", resp_unstable, 0);
`endif
      end else begin
         if (m_busy) begin
            if (m_valid && resp_ready) begin
               m_busy = 0; m_valid = 0;
            end else begin
               m_c++;
            end
         end else if (cmd_valid) begin
            m_busy = 1; m_c = 0; m_chal = cmd_challenge;
            for (int b = 0; b < 16; b++) begin
               int cnt;
               cnt = 0;
               for (int e = 0; e < c_n; e++) cnt += int'((cmd_challenge ^ 16'hA5A5 ^ drv_mask[e]) >> b) & 1;
               m_data[b] = (cnt > c_n / 2);
               m_unst[b] = (cnt != 0) && (cnt != c_n);
            end
            drv_e = 0; st_rises = 0; st_cycles = 0; rec_lat = -1;
         end
         exp_pulse = m_busy && (m_c < c_n * c_p) &&
                     ((m_c % c_p) >= c_setup) && ((m_c % c_p) < c_setup + c_pulse);
         m_valid = m_busy && (m_c >= c_n * c_p + 1);
         #1;
         chk("cmd_ready", cmd_ready, !m_busy);
         chk("busy", busy, m_busy);
         chk("puf_pulse", puf_pulse, exp_pulse);
         chk("resp_valid", resp_valid, m_valid);
         chk("puf_challenge", puf_challenge, m_chal);
         if (m_valid) begin
            chk("resp_data", resp_data, m_data);
`ifdef PAPUF_STABILITY_FLAG_EN
            chk("resp_unstable", resp_unstable, m_unst);
`endif
         end
         // PUF stand-in: each excitation yields challenge ^ A5A5 with that evaluation's noise.
         if (puf_pulse && !prev_pulse) begin
            puf_response = puf_challenge ^ 16'hA5A5 ^ drv_mask[drv_e];
            if (drv_e < 15) drv_e++;
            st_rises++;
         end
         if (puf_pulse) st_cycles++;
         if (resp_valid && !prev_valid) begin
            rec_lat = m_c; rec_data = resp_data;
`ifdef PAPUF_STABILITY_FLAG_EN
            rec_unst = resp_unstable;
`endif
         end
         prev_pulse = puf_pulse;
         prev_valid = resp_valid;
      end
   end

   task automatic set_masks(input bit rnd);
      for (int e = 0; e < 16; e++)
         drv_mask[e] = rnd ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'h0000;
   endtask

   task automatic run_txn(input logic [15:0] ch, input int hold, input bit rnd);
      @(negedge clk);
      cmd_challenge = ch; cmd_valid = 1'b1; resp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_challenge = 16'($urandom);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (resp_valid) break;
         resp_ready = rnd ? 1'($urandom) : 1'b0;
      end
      chk("resp_valid_seen", resp_valid, 1);
      resp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         cmd_valid = 1'($urandom); cmd_challenge = 16'($urandom);
      end
      cmd_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      set_masks(0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_txn(16'h1234, 0, 0);
      chk("t1_latency", rec_lat, 56);
      chk("t1_data", rec_data, 16'hB791);
      chk("t1_pulse_count", st_rises, 5);
      chk("t1_pulse_cycles", st_cycles, 20);

      set_masks(0); drv_mask[1] = 16'h0001; drv_mask[3] = 16'h0001;
      run_txn(16'hA55A, 0, 0);
      chk("t2_data", rec_data, 16'h00FF);
`ifdef PAPUF_STABILITY_FLAG_EN
      chk("t2_unstable", rec_unst, 16'h0001);
`endif

      set_masks(0); drv_mask[0] = 16'h0008; drv_mask[2] = 16'h0008; drv_mask[4] = 16'h0008;
      run_txn(16'hA5A5, 0, 0);
      chk("t3_data", rec_data, 16'h0008);
`ifdef PAPUF_STABILITY_FLAG_EN
      chk("t3_unstable", rec_unst, 16'h0008);
`endif

      set_masks(0);
      run_txn(16'h0F0F, 20, 0);
      chk("t4_data", rec_data, 16'hAAAA);
      chk("t4_idle_after_hs", cmd_ready, 1);

      for (int t = 0; t < 8; t++) begin
         set_masks(1);
         run_txn(16'($urandom), int'($urandom_range(0, 5)), 1);
      end

      // Abort in the second pulse cycle of evaluation 2.
      set_masks(0);
      @(negedge clk);
      cmd_challenge = 16'hC3C3; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #2;
         if (m_busy && m_c == 2 * c_p + c_setup + 1) break;
      end
      chk("abort_pulse_before", puf_pulse, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_pulse_async", puf_pulse, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_valid", resp_valid, 0);
      chk("abort_challenge", puf_challenge, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      drv_mask[1] = 16'h0001; drv_mask[3] = 16'h0001;
      run_txn(16'hA55A, 0, 0);
      chk("abort_next_latency", rec_lat, 56);
      chk("abort_next_data", rec_data, 16'h00FF);

      // Minimal configuration instance.
      begin
         int k;
         @(negedge clk);
         chk("min_ready", cmd_ready1, 1);
         cmd_challenge1 = 16'hFFFF; cmd_valid1 = 1'b1;
         @(posedge clk); #2;
         cmd_valid1 = 1'b0;
         k = 0;
         while (!resp_valid1 && k < 40) begin
            @(posedge clk); #2;
            k++;
         end
         chk("min_latency", k, 7);
         chk("min_data", resp_data1, 16'h5A5A);
`ifdef PAPUF_STABILITY_FLAG_EN
         chk("min_unstable", resp_unstable1, 16'h0000);
`endif
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/papuf_eval_ctrl.md
Name: papuf_eval_ctrl

Overview:
- Sequencer sitting directly upstream of a papuf16 array: accepts a 16-bit challenge, drives challenge and pulse into the PUF, then samples the asynchronous response.
- Repeats the evaluation NUM_EVAL times and returns a per-bit majority-voted 16-bit response over a valid/ready interface.
- Gives the system a clocked, noise-filtered view of the free-running PUF.

Parameters:
- NUM_EVAL, 5: evaluations per challenge; must be odd, range 1..15.
- SETUP_CYC, 2: cycles the challenge is stable with pulse low before each pulse; minimum 1.
- PULSE_CYC, 4: cycles puf_pulse is held high; minimum 1.
- SETTLE_CYC, 4: cycles after pulse falls before sampling; minimum 3, which covers the 2-flop synchronizer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  challenge request valid
- cmd_ready  out  1  controller idle, able to accept
- cmd_challenge  in  16  challenge to evaluate
- puf_challenge  out  16  challenge bus to PUF array
- puf_pulse  out  1  excitation pulse to PUF array
- puf_response  in  16  raw asynchronous PUF response
- resp_valid  out  1  voted response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  16  majority-voted response
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - puf_challenge = 0, puf_pulse = 0, resp_valid = 0, resp_data = 0, busy = 0, cmd_ready = 1.
  - All counters and synchronizer flops cleared.
- puf_response passes through a 2-flop synchronizer per bit, free-running every cycle.
- States: IDLE, SETUP, PULSE, SETTLE, SAMPLE, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch cmd_challenge into puf_challenge, clear vote counters and eval_cnt, then go to SETUP.
- SETUP: SETUP_CYC cycles with pulse low, then go to PULSE.
- PULSE:
  - puf_pulse = 1 (registered output) for exactly PULSE_CYC cycles.
  - Then go to SETTLE; pulse drops on the first SETTLE cycle.
- SETTLE: SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - For each bit i, vote_cnt[i] += sync_resp[i]. Each counter is clog2(NUM_EVAL+1) bits wide and cannot overflow.
  - eval_cnt++.
  - If the incremented eval_cnt == NUM_EVAL, go to DONE; otherwise go to SETUP.
- DONE:
  - resp_data[i] = (vote_cnt[i] > NUM_EVAL/2), registered on DONE entry.
  - resp_valid = 1, held stable with resp_data until resp_ready.
  - On resp_valid & resp_ready: clear resp_valid and go to IDLE. cmd_ready rises the next cycle; there is no same-cycle turnaround.
- Latency:
  - Per-evaluation period P = SETUP_CYC + PULSE_CYC + SETTLE_CYC + 1.
  - resp_valid rises N*P + 1 cycles after the accept edge. With defaults P = 11, so 56 cycles.
- puf_challenge holds from accept until the next accept, including through DONE and IDLE.
- cmd_valid outside IDLE is ignored (cmd_ready = 0); no queuing.
- resp_ready while resp_valid = 0 has no effect.
- Reset mid-operation:
  - puf_pulse falls immediately (asynchronous).
  - Partial votes are discarded, and no response is emitted for the aborted challenge.
- NUM_EVAL = 1 is legal: the single sample is passed straight through.

Optional Feature:
- Macro: PAPUF_STABILITY_FLAG_EN.
- When defined:
  - Adds output resp_unstable [15:0], valid with resp_data.
  - Bit i = 1 iff vote_cnt[i] is neither 0 nor NUM_EVAL, i.e. the evaluations disagreed.
  - Reset value 0; registered on DONE entry with resp_data.
- When undefined: the port does not exist and no extra logic is generated. All other behaviour is identical.

Test Plan:
- Fixed PUF model (response = challenge ^ 16'hA5A5); accept 16'h1234 with defaults, resp_ready = 1. Expected: resp_data = 16'hB791 exactly 56 cycles after accept; puf_pulse high 5 times, 4 cycles each.
- Noisy model flipping bit 0 on evaluations 1 and 3 (2 of 5), base 16'h00FF. Expected: resp_data = 16'h00FF. With PAPUF_STABILITY_FLAG_EN: resp_unstable = 16'h0001.
- Bit 3 flipped on evaluations 0, 2, 4 (3 of 5), base 16'h0000. Expected: resp_data = 16'h0008; resp_unstable = 16'h0008 if enabled.
- Hold resp_ready = 0 for 20 cycles after resp_valid. Expected: resp_valid and resp_data stable and cmd_ready = 0 throughout; cmd_valid pulses during this window are ignored; IDLE one cycle after the handshake.
- Assert rst_n = 0 in the 2nd PULSE cycle of evaluation 2. Expected: puf_pulse = 0 asynchronously, all outputs at reset values. A new challenge then completes in 56 cycles with a correct, uncontaminated vote.
- NUM_EVAL = 1, SETUP_CYC = 1, PULSE_CYC = 1, SETTLE_CYC = 3, challenge 16'hFFFF. Expected: resp_valid 7 cycles after accept, resp_data = 16'h5A5A.
